lsu_rr_arbiter_8: RTL and testbench
===================================

// Module: lsu_rr_arbiter_8
// PURPOSE
// Round-robin arbiter sharing one 32-bit LSU memory request port among 8 requesters.
// Picks a requester, drives the 8:1 data mux select, captures the selected word into an
// output register, and holds it under valid/ready backpressure until the memory side accepts.
// Sits between the LSU request sources and the single memory/store port.
// PARAMETERS
// DATA_W  32  width of each request data word and of mem_data_o
// N_REQ   8   number of requesters; fixed at 8 (select width 3), other values unsupported
// PORTS
// clk_i          in   1            clock, all logic on rising edge
// rst_ni         in   1            synchronous reset, active low
// req_valid_i    in   8            per-requester request valid
// req_data_i     in   8x32         per-requester request data ([7:0][31:0])
// req_ready_o    out  8            one-hot accept strobe; transfer = req_valid_i[k] & req_ready_o[k]
// mem_valid_o    out  1            registered request valid toward memory
// mem_ready_i    in   1            memory accepts mem_data_o when mem_valid_o & mem_ready_i
// mem_data_o     out  32           registered data of granted requester
// mem_sel_o      out  3            registered index of granted requester (mux select)
// BEHAVIOUR
// - Reset (rst_ni=0 at posedge): state=IDLE, ptr=0, mem_valid_o=0, mem_data_o=0, mem_sel_o=0.
//   req_ready_o=0 while rst_ni=0. Reset mid-transaction discards the held word; no replay.
// - State: IDLE (output register empty), BUSY (output register holds a word, mem_valid_o=1).
// - Accept window: open = (state==IDLE) | (state==BUSY & mem_ready_i).
// - Arbitration (combinational): search req_valid_i from index ptr upward, wrapping 7->0;
//   g = first set index. No request -> no grant.
// - req_ready_o = (open & any req_valid_i) ? onehot(g) : 8'h00. At most one bit set, ever.
// - On accept (open & any req): mem_data_o<=req_data_i[g], mem_sel_o<=g, mem_valid_o<=1,
//   ptr<=(g+1) mod 8, state<=BUSY. Latency request->mem_valid_o: 1 cycle.
// - BUSY & mem_ready_i & no request: mem_valid_o<=0, state<=IDLE; mem_data_o/mem_sel_o hold.
// - BUSY & ~mem_ready_i: all registers hold; req_ready_o=0.
// - Back-to-back: handshake and new accept in the same cycle -> one word per cycle sustained.
// - Requesters hold valid and data stable until accepted; arbiter never drops a held word
//   except on reset. A requester dropping valid before accept is simply not granted.
// - ptr changes only on accept; idle cycles and stall cycles do not advance it.
// - Fairness: with all 8 requesting continuously, each is granted exactly once per 8 accepts.
// - mem_ready_i is ignored in IDLE (mem_valid_o=0).
// TESTING
// 1. Reset: rst_ni=0 2 cycles, req_valid_i=8'hFF -> req_ready_o=0, mem_valid_o=0,
//    mem_data_o=0, mem_sel_o=0; after release first grant is requester 0.
// 2. Single: req_valid_i=8'h08, req_data_i[3]=32'hA5A5_0003, mem_ready_i=1 ->
//    req_ready_o=8'h08 in cycle 0; cycle 1 mem_valid_o=1, mem_data_o=32'hA5A5_0003, mem_sel_o=3.
// 3. Full load: req_valid_i=8'hFF held, mem_ready_i=1 -> mem_sel_o sequence 0,1,...,7,0,
//    one per cycle, mem_valid_o continuously 1.
// 4. Backpressure: word from requester 2 held, mem_ready_i=0 for 5 cycles -> mem_valid_o=1,
//    mem_data_o/mem_sel_o stable, req_ready_o=0 every stall cycle; grant resumes on ready.
// 5. Wrap: grant 6 (ptr=7), then req_valid_i=8'h81 -> grants 7 then 0.
// 6. Reset in BUSY with mem_ready_i=0 -> next cycle mem_valid_o=0, ptr=0; with
//    req_valid_i=8'h24 the next grant is requester 2.

Source files
------------

// File: rtl/lsu_rr_arbiter_8.sv
// Round-robin arbiter that shares one registered 32-bit LSU memory request port among 8 requesters.
// State | meaning:  IDLE | output register empty;  BUSY | output register holds a word, mem_valid_o=1
module lsu_rr_arbiter_8 #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic                         mem_valid_o,
    input  logic                         mem_ready_i,
    output logic [DATA_W-1:0]            mem_data_o,
    output logic [2:0]                   mem_sel_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [2:0]          sel_q, sel_d;

    logic                found;
    logic [2:0]          grant_idx;
    logic                open_win;
    logic                accept;

    // Rotating priority search starting at ptr_q, wrapping 7 -> 0.
    always_comb begin
        found     = 1'b0;
        grant_idx = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid_i[ptr_q + 3'(i)]) begin
                found     = 1'b1;
                grant_idx = ptr_q + 3'(i);
            end
        end
    end

    assign open_win = (state_q == IDLE) || mem_ready_i;
    assign accept   = rst_ni && open_win && found;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (accept) begin
            state_d = BUSY;
            ptr_d   = grant_idx + 3'd1;
            data_d  = req_data_i[grant_idx];
            sel_d   = grant_idx;
        end else if (state_q == BUSY && mem_ready_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            data_q  <= '0;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    // Valid is the registered BUSY state itself.
    assign mem_valid_o = (state_q == BUSY);
    assign mem_data_o  = data_q;
    assign mem_sel_o   = sel_q;

endmodule

// File: tb/tb_lsu_rr_arbiter_8.sv
// Scoreboard bench for lsu_rr_arbiter_8: stimulus pushes expected {sel,data}; a negedge monitor pops on each handshake.
module tb_lsu_rr_arbiter_8;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [7:0]       req_valid_i;
    logic [7:0][31:0] req_data_i;
    logic [7:0]       req_ready_o;
    logic             mem_valid_o;
    logic             mem_ready_i;
    logic [31:0]      mem_data_o;
    logic [2:0]       mem_sel_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [34:0] sb[$];

    lsu_rr_arbiter_8 dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_data_o  (mem_data_o),
        .mem_sel_o   (mem_sel_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Called at the #1 point of the accept cycle: grant must be k; queue its word.
    task automatic expect_grant(input int k);
        check($sformatf("grant_%0d", k), 32'(req_ready_o), 32'(8'h01 << k));
        sb.push_back({3'(k), req_data_i[k]});
    endtask

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && mem_valid_o === 1'b1 && mem_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: sel %0d data %h with empty scoreboard", mem_sel_o, mem_data_o);
            end else begin
                logic [34:0] e;
                e = sb.pop_front();
                check("mon_sel", 32'(mem_sel_o), 32'(e[34:32]));
                check("mon_data", mem_data_o, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 8; k++) req_data_i[k] = 32'hC0DE_0000 | 32'(k);
        rst_ni      = 1'b0;
        req_valid_i = 8'hFF;
        mem_ready_i = 1'b1;

        // 1. reset
        step();
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_valid", 32'(mem_valid_o), 32'h0);
        check("rst_data", mem_data_o, 32'h0);
        check("rst_sel", 32'(mem_sel_o), 32'h0);
        step();
        check("rst_ready2", 32'(req_ready_o), 32'h0);
        rst_ni = 1'b1;
        #1;
        expect_grant(0);
        step();
        req_valid_i = 8'h00;
        step();
        check("idle_valid", 32'(mem_valid_o), 32'h0);

        // 2. single request from 3 (ptr=1)
        req_data_i[3] = 32'hA5A5_0003;
        req_valid_i   = 8'h08;
        #1;
        expect_grant(3);
        step();
        req_valid_i = 8'h00;
        check("single_valid", 32'(mem_valid_o), 32'h1);
        check("single_data", mem_data_o, 32'hA5A5_0003);
        check("single_sel", 32'(mem_sel_o), 32'd3);
        step();

        // 3. full load from ptr=0
        rst_ni = 1'b0;
        step();
        rst_ni      = 1'b1;
        req_valid_i = 8'hFF;
        #1;
        for (int i = 0; i < 9; i++) begin
            expect_grant(i % 8);
            step();
            check("full_valid", 32'(mem_valid_o), 32'h1);
        end
        req_valid_i = 8'h00;
        step();

        // 4. backpressure on word from 2 (ptr=1)
        req_valid_i = 8'h04;
        #1;
        expect_grant(2);
        step();
        req_valid_i = 8'h10;
        mem_ready_i = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_ready", 32'(req_ready_o), 32'h0);
            check("stall_valid", 32'(mem_valid_o), 32'h1);
            check("stall_sel", 32'(mem_sel_o), 32'd2);
            check("stall_data", mem_data_o, req_data_i[2]);
            step();
        end
        mem_ready_i = 1'b1;
        #1;
        expect_grant(4);
        step();
        req_valid_i = 8'h00;
        step();

        // 5. wrap: 6, then 7 and 0 from 8'h81 (ptr=5)
        req_valid_i = 8'h40;
        #1;
        expect_grant(6);
        step();
        req_valid_i = 8'h81;
        #1;
        expect_grant(7);
        step();
        expect_grant(0);
        step();
        req_valid_i = 8'h00;
        step();

        // 6. reset while BUSY and stalled (ptr=1)
        req_valid_i = 8'h08;
        #1;
        expect_grant(3);
        step();
        req_valid_i = 8'h00;
        mem_ready_i = 1'b0;
        rst_ni      = 1'b0;
        step();
        sb.delete();
        check("rstbusy_valid", 32'(mem_valid_o), 32'h0);
        check("rstbusy_ready", 32'(req_ready_o), 32'h0);
        rst_ni      = 1'b1;
        mem_ready_i = 1'b1;
        req_valid_i = 8'h24;
        #1;
        expect_grant(2);
        step();
        req_valid_i = 8'h00;
        step();
        step();

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
